// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared widths, constants and helpers for the writeback slice
// Purpose: default address/data widths, the hard-wired zero register address,
//          and the FIFO pointer width helper used by regwb_fifo and the top.
// Ports:   none (package).
package regfile_writeback_pkg;

  localparam int REGWB_AW    = 5;
  localparam int REGWB_DW    = 32;
  localparam int REGWB_NREGS = 32;

  localparam logic [REGWB_AW-1:0] REG_ZERO = '0;

  // Pointer width for a power-of-2 FIFO depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - long-latency result handshake into the writeback block
// Purpose: groups the valid/ready result channel from the long-latency unit.
// Ports:   lu_valid (result valid), lu_ready (FIFO can accept),
//          lu_wa (destination register), lu_wd (result data).
//          master = long-latency unit, slave = regfile_writeback.
interface regfile_writeback_if
  import regfile_writeback_pkg::*;
#(
  parameter int AW = REGWB_AW,
  parameter int DW = REGWB_DW
) ();

  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_wa;
  logic [DW-1:0] lu_wd;

  modport master (output lu_valid, lu_wa, lu_wd, input lu_ready);
  modport slave  (input lu_valid, lu_wa, lu_wd, output lu_ready);

endinterface

// File: rtl/regwb_fifo.sv
// rtl/regwb_fifo.sv - small synchronous FIFO buffering long-latency results
// Purpose: DEPTH-entry FIFO (DEPTH a power of 2, >= 2) with wrapping pointers.
// Ports:   clock, reset (async active-low), push_i/wdata_i (write side),
//          pop_i/rdata_o (read side, rdata_o shows the head), count_o
//          (occupancy), full_o, empty_o. Push when full and pop when empty
//          are ignored.
module regwb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [W-1:0]                wdata_i,
  output logic [W-1:0]                rdata_o,
  output logic [ptr_width(DEPTH):0]   count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int PW = ptr_width(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are PW bits wide, so +1 wraps modulo DEPTH.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write port arbiter with long-latency scoreboard
// Purpose: merges ALU writeback (never stalled, highest priority) and buffered
//          long-latency results onto the single register file write port, and
//          tracks outstanding long-latency destinations to raise decode stalls.
// Ports:   clock, reset (async active-low); issue_valid/issue_rd (long-latency
//          issue); alu_wen/alu_wa/alu_wd (pipeline writeback); lu (result
//          handshake, slave modport); chk_raA/chk_raB (decode read addresses);
//          stall; rf_wa/rf_wen/rf_wd (register file write port); pending
//          (scoreboard); fifo_count; wb_err (sticky protocol error).
// Option:  REGWB_EARLY_RELEASE_EN - drop the hazard on the FIFO head register
//          one cycle early when that entry is guaranteed to pop at the next edge.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = REGWB_DW,
  parameter int AW    = REGWB_AW
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [AW-1:0]             issue_rd,
  input  logic                      alu_wen,
  input  logic [AW-1:0]             alu_wa,
  input  logic [DW-1:0]             alu_wd,
  regfile_writeback_if.slave        lu,
  input  logic [AW-1:0]             chk_raA,
  input  logic [AW-1:0]             chk_raB,
  output logic                      stall,
  output logic [AW-1:0]             rf_wa,
  output logic                      rf_wen,
  output logic [DW-1:0]             rf_wd,
  output logic [REGWB_NREGS-1:0]    pending,
  output logic [ptr_width(DEPTH):0] fifo_count,
  output logic                      wb_err
);

  logic [AW+DW-1:0]       head;
  logic [AW-1:0]          head_wa;
  logic [DW-1:0]          head_wd;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop, alu_take;

  logic [AW-1:0]          rf_wa_q, rf_wa_d;
  logic                   rf_wen_q, rf_wen_d;
  logic [DW-1:0]          rf_wd_q, rf_wd_d;
  logic [REGWB_NREGS-1:0] pending_q, pending_d;
  logic                   wb_err_q, wb_err_d;
  logic [REGWB_NREGS-1:0] pend_vis;

  assign {head_wa, head_wd} = head;

  assign lu.lu_ready = ~fifo_full;
  assign push        = lu.lu_valid & ~fifo_full;
  // ALU writes to register 0 are dropped and do not block the FIFO.
  assign alu_take    = alu_wen & (alu_wa != AW'(REG_ZERO));
  // Empty comes from registered state, so a fresh push cannot pop in its own cycle.
  assign pop         = ~alu_take & ~fifo_empty;

  regwb_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({lu.lu_wa, lu.lu_wd}),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    rf_wa_d   = rf_wa_q;
    rf_wd_d   = rf_wd_q;
    rf_wen_d  = 1'b0;
    pending_d = pending_q;
    wb_err_d  = wb_err_q;

    if (alu_take) begin
      rf_wa_d  = alu_wa;
      rf_wd_d  = alu_wd;
      rf_wen_d = 1'b1;
    end else if (pop) begin
      rf_wa_d  = head_wa;
      rf_wd_d  = head_wd;
      rf_wen_d = (head_wa != AW'(REG_ZERO));
    end

    // Clear before set so an issue to the register being retired keeps it pending.
    if (pop) pending_d[head_wa] = 1'b0;
    if (issue_valid && issue_rd != AW'(REG_ZERO)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;

    if ((alu_wen && pending_q[alu_wa]) || (pop && !pending_q[head_wa])) wb_err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_wa_q   <= '0;
      rf_wen_q  <= 1'b0;
      rf_wd_q   <= '0;
      pending_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      rf_wa_q   <= rf_wa_d;
      rf_wen_q  <= rf_wen_d;
      rf_wd_q   <= rf_wd_d;
      pending_q <= pending_d;
      wb_err_q  <= wb_err_d;
    end
  end

  always_comb begin
    pend_vis = pending_q;
`ifdef REGWB_EARLY_RELEASE_EN
    // The head write lands at the negedge before the dependent read, so its
    // hazard can be released as soon as the pop is certain.
    if (pop && head_wa != AW'(REG_ZERO)) pend_vis[head_wa] = 1'b0;
`else
    pend_vis = pending_q;
`endif
  end

  assign stall   = pend_vis[chk_raA] | pend_vis[chk_raB] | (issue_valid & pend_vis[issue_rd]);
  assign rf_wa   = rf_wa_q;
  assign rf_wen  = rf_wen_q;
  assign rf_wd   = rf_wd_q;
  assign pending = pending_q;
  assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - self-checking bench for regfile_writeback
module tb_regfile_writeback;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          alu_wen;
  logic [AW-1:0] alu_wa;
  logic [DW-1:0] alu_wd;
  logic [AW-1:0] chk_raA, chk_raB;
  logic          stall, rf_wen, wb_err;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [31:0]   pending;
  logic [2:0]    fifo_count;

  always #5 clock = ~clock;

  regfile_writeback_if #(.AW(AW), .DW(DW)) lu_if ();

  regfile_writeback #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_wen     (alu_wen),
    .alu_wa      (alu_wa),
    .alu_wd      (alu_wd),
    .lu          (lu_if),
    .chk_raA     (chk_raA),
    .chk_raB     (chk_raB),
    .stall       (stall),
    .rf_wa       (rf_wa),
    .rf_wen      (rf_wen),
    .rf_wd       (rf_wd),
    .pending     (pending),
    .fifo_count  (fifo_count),
    .wb_err      (wb_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } ent_t;

  ent_t          q[$];
  logic [31:0]   m_pend;
  logic          m_wen;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic          m_err;
  bit            cmp_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = '0;
    m_wen  = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
    m_err  = 1'b0;
  endtask

  // One clock edge of the writeback rules, from the inputs present at that edge.
  task automatic model_step();
    ent_t        e;
    logic [31:0] p;
    bit          was_full;
    p        = m_pend;
    was_full = (q.size() == DEPTH);
    if (alu_wen && alu_wa != 0) begin
      if (p[alu_wa]) m_err = 1'b1;
      m_wen = 1'b1; m_wa = alu_wa; m_wd = alu_wd;
    end else if (q.size() > 0) begin
      if (alu_wen && p[alu_wa]) m_err = 1'b1;
      e = q.pop_front();
      if (!p[e.wa]) m_err = 1'b1;
      m_wen = (e.wa != 0); m_wa = e.wa; m_wd = e.wd;
      m_pend[e.wa] = 1'b0;
    end else begin
      if (alu_wen && p[alu_wa]) m_err = 1'b1;
      m_wen = 1'b0;
    end
    if (lu_if.lu_valid && !was_full) q.push_back('{wa: lu_if.lu_wa, wd: lu_if.lu_wd});
    if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    m_pend[0] = 1'b0;
  endtask

  function automatic logic m_stall();
    logic [31:0] p;
    p = m_pend;
`ifdef REGWB_EARLY_RELEASE_EN
    if (q.size() > 0 && !(alu_wen && alu_wa != 0) && q[0].wa != 0) p[q[0].wa] = 1'b0;
`endif
    return p[chk_raA] | p[chk_raB] | (issue_valid & p[issue_rd]);
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("rf_wen", 64'(rf_wen), 64'(m_wen));
      chk("rf_wa", 64'(rf_wa), 64'(m_wa));
      chk("rf_wd", 64'(rf_wd), 64'(m_wd));
      chk("pending", 64'(pending), 64'(m_pend));
      chk("fifo_count", 64'(fifo_count), 64'(q.size()));
      chk("lu_ready", 64'(lu_if.lu_ready), 64'(q.size() != DEPTH));
      chk("wb_err", 64'(wb_err), 64'(m_err));
      chk("stall", 64'(stall), 64'(m_stall()));
    end
  end

  task automatic clear_inputs();
    issue_valid = 0; issue_rd = 0;
    alu_wen = 0; alu_wa = 0; alu_wd = 0;
    chk_raA = 0; chk_raB = 0;
    lu_if.lu_valid = 0; lu_if.lu_wa = 0; lu_if.lu_wd = 0;
  endtask

  task automatic step();
    @(posedge clock);
    if (reset) model_step();
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    clear_inputs();
    do_reset();
    cmp_en = 1;

    // ALU path and register-0 suppression
    alu_wen = 1; alu_wa = 5; alu_wd = 32'hDEAD_BEEF;
    step();
    chk("alu_wen", 64'(rf_wen), 64'd1);
    chk("alu_wa", 64'(rf_wa), 64'd5);
    chk("alu_wd", 64'(rf_wd), 64'hDEAD_BEEF);
    alu_wa = 0; alu_wd = 32'h1;
    step();
    chk("r0_wen", 64'(rf_wen), 64'd0);
    chk("r0_hold_wa", 64'(rf_wa), 64'd5);
    alu_wen = 0;

    // ALU priority over a buffered result, then drain
    issue_valid = 1; issue_rd = 9;
    step();
    chk("pend9", 64'(pending), 64'h200);
    issue_valid = 0; chk_raA = 9;
    lu_if.lu_valid = 1; lu_if.lu_wa = 9; lu_if.lu_wd = 32'h1234;
    alu_wen = 1; alu_wa = 4; alu_wd = 32'h44;
    step();
    lu_if.lu_valid = 0;
    chk("prio_cnt", 64'(fifo_count), 64'd1);
    chk("prio_wa", 64'(rf_wa), 64'd4);
    step();
    step();
    alu_wen = 0;
    #1;
`ifdef REGWB_EARLY_RELEASE_EN
    chk("early_stall", 64'(stall), 64'd0);
`else
    chk("early_stall", 64'(stall), 64'd1);
`endif
    step();
    chk("drain_wa", 64'(rf_wa), 64'd9);
    chk("drain_wd", 64'(rf_wd), 64'h1234);
    chk("drain_pend", 64'(pending), 64'd0);
    chk("drain_stall", 64'(stall), 64'd0);
    chk_raA = 0;

    // Fill to DEPTH behind continuous ALU traffic, reject 5th, drain in order
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; issue_rd = AW'(10 + i);
      step();
    end
    issue_valid = 0;
    alu_wen = 1; alu_wa = 6; alu_wd = 32'h66;
    for (int i = 0; i < 5; i++) begin
      lu_if.lu_valid = 1; lu_if.lu_wa = AW'(10 + i); lu_if.lu_wd = 32'(100 + i);
      step();
      chk("fill_cnt", 64'(fifo_count), 64'((i < 4) ? i + 1 : 4));
      chk("fill_ready", 64'(lu_if.lu_ready), 64'((i >= 3) ? 0 : 1));
    end
    lu_if.lu_valid = 0; alu_wen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("order_wa", 64'(rf_wa), 64'(10 + i));
      chk("order_wd", 64'(rf_wd), 64'(100 + i));
    end
    chk("order_pend", 64'(pending), 64'd0);
    chk("order_err", 64'(wb_err), 64'd0);

    // WAW stall and ALU write to a pending register
    do_reset();
    issue_valid = 1; issue_rd = 7;
    step();
    #1;
    chk("waw_stall", 64'(stall), 64'd1);
    step();
    issue_valid = 0;
    chk("waw_err0", 64'(wb_err), 64'd0);
    alu_wen = 1; alu_wa = 7; alu_wd = 32'h77;
    step();
    chk("waw_err1", 64'(wb_err), 64'd1);
    alu_wen = 0;

    // Same-cycle issue and pop of the same register: set wins
    do_reset();
    issue_valid = 1; issue_rd = 3;
    step();
    issue_valid = 0;
    lu_if.lu_valid = 1; lu_if.lu_wa = 3; lu_if.lu_wd = 32'h33;
    step();
    lu_if.lu_valid = 0;
    chk("setwin_cnt", 64'(fifo_count), 64'd1);
    issue_valid = 1; issue_rd = 3;
    step();
    issue_valid = 0;
    chk("setwin_pend", 64'(pending), 64'h8);
    chk("setwin_wa", 64'(rf_wa), 64'd3);
    chk("setwin_err", 64'(wb_err), 64'd0);

    // Asynchronous reset in the middle of traffic
    do_reset();
    issue_valid = 1; issue_rd = 1;
    step();
    issue_rd = 2; alu_wen = 1; alu_wa = 20; alu_wd = 32'h20;
    lu_if.lu_valid = 1; lu_if.lu_wa = 1; lu_if.lu_wd = 32'h11;
    step();
    issue_valid = 0; lu_if.lu_wa = 2; lu_if.lu_wd = 32'h22;
    step();
    lu_if.lu_valid = 0;
    chk("pre_rst_pend", 64'(pending), 64'h6);
    chk("pre_rst_cnt", 64'(fifo_count), 64'd2);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_wen", 64'(rf_wen), 64'd0);
    chk("rst_cnt", 64'(fifo_count), 64'd0);
    chk("rst_pend", 64'(pending), 64'd0);
    chk("rst_ready", 64'(lu_if.lu_ready), 64'd1);
    do_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      issue_valid    = ($urandom_range(0, 3) == 0);
      issue_rd       = AW'($urandom_range(0, 7));
      alu_wen        = ($urandom_range(0, 2) == 0);
      alu_wa         = AW'($urandom_range(0, 7));
      alu_wd         = $urandom;
      lu_if.lu_valid = ($urandom_range(0, 1) == 0);
      lu_if.lu_wa    = AW'($urandom_range(0, 7));
      lu_if.lu_wd    = $urandom;
      chk_raA        = AW'($urandom_range(0, 7));
      chk_raB        = AW'($urandom_range(0, 7));
      step();
      if (c % 200 == 199) do_reset();
    end

    @(negedge clock);
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
Write-side initiator for the 32x32 register file. It merges two writeback sources onto the register file's single write port (wa/wen/wd):
- the in-order pipeline (ALU results), which is never stalled;
- a long-latency unit (multiply/divide or load), connected by a valid/ready handshake and buffered in a small FIFO.
A scoreboard tracks destination registers with outstanding long-latency results and raises a stall on RAW/WAW hazards.

Parameters:
DEPTH, 4, long-latency result FIFO depth; power of 2, at least 2
DW, 32, data width
AW, 5, register address width

Ports:
clock  input  1  system clock; outputs update on posedge, register file samples on negedge
reset  input  1  asynchronous, active-low
issue_valid  input  1  long-latency op issued this cycle
issue_rd  input  AW  destination register of issued op
alu_wen  input  1  pipeline writeback request
alu_wa  input  AW  pipeline writeback address
alu_wd  input  DW  pipeline writeback data
lu_valid  input  1  long-latency result valid
lu_ready  output  1  FIFO can accept a result
lu_wa  input  AW  long-latency result address
lu_wd  input  DW  long-latency result data
chk_raA  input  AW  decode-stage read address A
chk_raB  input  AW  decode-stage read address B
stall  output  1  hazard; decode must hold
rf_wa  output  AW  to register file wa
rf_wen  output  1  to register file wen
rf_wd  output  DW  to register file wd
pending  output  32  scoreboard bit vector
fifo_count  output  log2(DEPTH)+1  FIFO occupancy
wb_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (reset=0, async): rf_wen=0, rf_wa=0, rf_wd=0; FIFO empty (fifo_count=0); pending=0; wb_err=0. Reset mid-operation discards buffered results and all pending bits.
- FIFO push: at posedge when lu_valid && lu_ready.
- lu_ready = (fifo_count != DEPTH). It is computed from registered state only.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Read/write pointers wrap modulo DEPTH.
- Arbiter, evaluated each posedge:
  - If alu_wen && alu_wa != 0: rf_* <= alu_*, rf_wen <= 1. The FIFO is not popped.
  - Else if FIFO not empty: rf_* <= head, rf_wen <= (head wa != 0), pop.
  - Else: rf_wen <= 0; rf_wa/rf_wd hold their values.
- Writes to register 0 never assert rf_wen. A register-0 FIFO entry is still popped.
- Latency:
  - ALU path: request at edge N; rf_wen high after edge N; register file written at the following negedge.
  - Long-latency path into an empty FIFO with no ALU traffic: pushed at edge N, driven after edge N+1.
  - Simultaneous push and pop on a non-empty FIFO: count unchanged.
  - A push into an empty FIFO cannot pop in the same cycle.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets pending[issue_rd] at posedge.
  - A FIFO pop with address wa clears pending[wa].
  - Set and clear of the same register in the same cycle: set wins.
  - pending[0] is always 0.
- stall (combinational) = pending[chk_raA] | pending[chk_raB] | (issue_valid & pending[issue_rd]).
- wb_err is set (sticky until reset) when either:
  - an ALU write targets a register whose pending bit is set, or
  - a FIFO pop targets a register whose pending bit is clear (unmatched result).
  The write still proceeds in both cases.

Optional Feature:
REGWB_EARLY_RELEASE_EN
- Defined: stall ignores pending bits for the register currently at the FIFO head when that entry will pop at the next edge (FIFO non-empty, no competing valid ALU write, head wa != 0). This releases the hazard one cycle earlier. The data is in the register file by the time the stalled read resolves, because the write lands at the negedge before the dependent read.
- Undefined: stall holds until the pending bit has actually cleared.

Decomposition:
- Shared package/header:
  - AW and DW defaults;
  - register-0 address constant;
  - FIFO pointer width function.
- One natural sub-module: regwb_fifo (parameterised DEPTH/width, push/pop/count/full/empty), instantiated once for {wa, wd}.
- Arbiter and scoreboard stay in the top level.

Test Plan:
- Reset low mid-traffic (2 FIFO entries, pending=0x0000_0006) -> immediately rf_wen=0, fifo_count=0, pending=0, lu_ready=1.
- alu_wen=1, wa=5, wd=0xDEAD_BEEF -> after next posedge rf_wen=1, rf_wa=5, rf_wd=0xDEAD_BEEF; wa=0 request -> rf_wen stays 0.
- issue rd=9, then lu result wa=9, wd=0x1234 with alu_wen held high for 3 cycles:
  - ALU wins for 3 cycles; the FIFO entry drains on cycle 4;
  - pending[9] clears; stall with chk_raA=9 stays 1 until the clear (one cycle earlier with REGWB_EARLY_RELEASE_EN).
- Push DEPTH=4 results while alu_wen=1 continuously -> lu_ready=0 at count 4; 5th lu_valid is not accepted; draining after alu_wen drops preserves FIFO order, and pointers wrap.
- issue_valid rd=7 twice without result -> second issue sees stall=1 (WAW); ALU write to reg 7 while pending -> wb_err=1.
- Same-cycle issue rd=3 and FIFO pop of wa=3 -> pending[3] remains 1.
